// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Arbitrates the instruction-fetch request and the data load/store request
//   onto a single shared RAM port. Data has fixed priority over fetch, so a
//   pending load/store always completes before the next fetch is granted.
//   RAM-side outputs are registered at the grant edge and held for the whole
//   request state. The hit is combinational on ram_ready, and load data is
//   passed straight through from ramload.
//
//   An optional watchdog aborts a request that waits TIMEOUT cycles without
//   ram_ready. It issues no hit and sets a sticky err flag. Setting TIMEOUT to
//   0 disables the watchdog.
//
// Optional feature:
//   MEM_ARBITER_STATS_EN - when defined, adds the icount and dcount outputs.
//   These are 32-bit wrapping counts of ihit and dhit cycles.
//
// Parameters:
//   WORD_W   width of addresses and data words
//   TIMEOUT  maximum wait cycles in a request state (0 = watchdog disabled)
//
// Ports:
//   CLK, nRST                rising-edge clock, asynchronous active-low reset
//   iREN, iaddr              instruction read request and its address
//   ihit, iload              instruction complete, fetched word (0 when no hit)
//   dREN, dWEN, daddr,       data request; dREN and dWEN both high is a write
//   dstore
//   dhit, dload              data complete, load data (0 when no hit)
//   ramREN, ramWEN, ramaddr, registered RAM strobes, address and write data
//   ramstore
//   ramload, ram_ready       RAM read data, access completes this cycle
//   err                      sticky watchdog-timeout flag
//   icount, dcount           hit counters (only with MEM_ARBITER_STATS_EN)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount
`endif
);

  // When the watchdog is disabled, keep a 1-bit counter so that no
  // declaration has zero width. The counter is never advanced in that case.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT > 0);
  // The abort fires on the wait cycle whose increment would make the count
  // reach TIMEOUT. As a result, the strobes are held for exactly TIMEOUT
  // waiting cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DREQ = 2'd1,
    IREQ = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic                ramREN_q,   ramREN_d;
  logic                ramWEN_q,   ramWEN_d;
  logic [WORD_W-1:0]   ramaddr_q,  ramaddr_d;
  logic [WORD_W-1:0]   ramstore_q, ramstore_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                err_q,      err_d;

  // State and registered RAM-side outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramREN_q   <= ramREN_d;
      ramWEN_q   <= ramWEN_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic. By default every register holds its value. This keeps
  // the RAM address and write data stable through a request, and leaves the
  // address unchanged after the request completes.
  always_comb begin
    state_d    = state_q;
    ramREN_d   = ramREN_q;
    ramWEN_d   = ramWEN_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          // A write takes precedence over a read when both are raised.
          state_d    = DREQ;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          ramWEN_d   = dWEN;
          ramREN_d   = ~dWEN;
          cnt_d      = '0;
        end else if (iREN) begin
          state_d   = IREQ;
          ramaddr_d = iaddr;
          ramREN_d  = 1'b1;
          ramWEN_d  = 1'b0;
          cnt_d     = '0;
        end
      end

      DREQ, IREQ: begin
        if (ram_ready) begin
          // Completion wins, even on the cycle the watchdog would fire.
          state_d  = IDLE;
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          state_d  = IDLE;
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
          err_d    = 1'b1;
          cnt_d    = CNT_MAX;
        end else if (WDOG_EN && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        ramREN_d = 1'b0;
        ramWEN_d = 1'b0;
      end
    endcase
  end

  // A hit is combinational on ram_ready in the matching request state, so
  // the two hits can never be asserted together.
  assign dhit = (state_q == DREQ) && ram_ready;
  assign ihit = (state_q == IREQ) && ram_ready;

  assign dload = dhit ? ramload : '0;
  assign iload = ihit ? ramload : '0;

  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign err      = err_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] icount_q, icount_d;
  logic [31:0] dcount_q, dcount_d;

  // Hit counters. They wrap naturally at 2^32. Timeouts never produce a hit,
  // so they are not counted.
  always_comb begin
    icount_d = icount_q;
    dcount_d = dcount_q;
    if (ihit) icount_d = icount_q + 32'd1;
    if (dhit) dcount_d = dcount_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
    end
  end

  assign icount = icount_q;
  assign dcount = dcount_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int W = 32;

  logic          CLK;
  logic          nRST;
  logic          iREN;
  logic [W-1:0]  iaddr;
  logic          ihit;
  logic [W-1:0]  iload;
  logic          dREN;
  logic          dWEN;
  logic [W-1:0]  daddr;
  logic [W-1:0]  dstore;
  logic          dhit;
  logic [W-1:0]  dload;
  logic          ramREN;
  logic          ramWEN;
  logic [W-1:0]  ramaddr;
  logic [W-1:0]  ramstore;
  logic [W-1:0]  ramload;
  logic          ram_ready;
  logic          err;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0]   icount;
  logic [31:0]   dcount;
`endif

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WORD_W(W), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
`ifdef MEM_ARBITER_STATS_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0;
    dstore = '0; ramload = 32'hFFFF_FFFF; ram_ready = 1'b1;
    @(negedge CLK); iREN = 1'b1; dREN = 1'b1;
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ramREN got %b want 0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rst_ramWEN got %b want 0", ramWEN); end
    checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rst_ramaddr got %h want 0", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL rst_ramstore got %h want 0", ramstore); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if ({ihit, dhit} !== 2'b00) begin errors++; $display("FAIL rst_hits got %b want 00", {ihit, dhit}); end
    checks++; if ({iload, dload} !== 64'h0) begin errors++; $display("FAIL rst_loads got %h want 0", {iload, dload}); end
    iREN = 0; dREN = 0; ram_ready = 0; nRST = 1'b1;
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_release_ramREN got %b want 0", ramREN); end
  endtask

  task automatic test_fetch();
    @(negedge CLK); iREN = 1; iaddr = 32'h40; ram_ready = 0; #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL fetch_pregrant_ramREN got %b want 0", ramREN); end
    @(negedge CLK); ram_ready = 1; ramload = 32'h8C22_0004; #1;
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL fetch_ramREN got %b want 1", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL fetch_ramWEN got %b want 0", ramWEN); end
    checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_ramaddr got %h want 40", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL fetch_ramstore got %h want 0", ramstore); end
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL fetch_ihit got %b want 1", ihit); end
    checks++; if (iload !== 32'h8C22_0004) begin errors++; $display("FAIL fetch_iload got %h want 8c220004", iload); end
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL fetch_dhit got %b want 0", dhit); end
    iREN = 0;
    @(negedge CLK); ram_ready = 0; #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL fetch_done_ramREN got %b want 0", ramREN); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL fetch_done_ihit got %b want 0", ihit); end
    checks++; if (iload !== 32'h0) begin errors++; $display("FAIL fetch_done_iload got %h want 0", iload); end
    checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_addr_hold got %h want 40", ramaddr); end
  endtask

  task automatic test_simultaneous();
    @(negedge CLK); iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100; ram_ready = 0;
    @(negedge CLK); #1;
    checks++; if (ramaddr !== 32'h100) begin errors++; $display("FAIL sim_data_first_addr got %h want 100", ramaddr); end
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL sim_wait_dhit got %b want 0", dhit); end
    ram_ready = 1; ramload = 32'hDEAD_BEEF; #1;
    checks++; if (dhit !== 1'b1) begin errors++; $display("FAIL sim_dhit got %b want 1", dhit); end
    checks++; if (dload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_dload got %h want deadbeef", dload); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL sim_ihit_excl got %b want 0", ihit); end
    checks++; if (iload !== 32'h0) begin errors++; $display("FAIL sim_iload_zero got %h want 0", iload); end
    dREN = 0;
    @(negedge CLK); ram_ready = 0; #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL sim_idle_ramREN got %b want 0", ramREN); end
    @(negedge CLK); #1;
    checks++; if (ramaddr !== 32'h80) begin errors++; $display("FAIL sim_fetch_addr got %h want 80", ramaddr); end
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL sim_fetch_ramREN got %b want 1", ramREN); end
    ram_ready = 1; ramload = 32'h1111_2222; #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL sim_ihit got %b want 1", ihit); end
    checks++; if (iload !== 32'h1111_2222) begin errors++; $display("FAIL sim_iload got %h want 11112222", iload); end
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL sim_dhit_excl got %b want 0", dhit); end
    iREN = 0;
    @(negedge CLK); ram_ready = 0;
  endtask

  task automatic test_store();
    @(negedge CLK); dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'h1234; ram_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      // Request-side inputs change after the grant; RAM outputs must not follow.
      daddr = 32'h999 + k; dstore = 32'hFFFF; #1;
      checks++; if ({ramWEN, ramREN} !== 2'b10) begin errors++; $display("FAIL store_strobes_w%0d got %b want 10", k, {ramWEN, ramREN}); end
      checks++; if (ramstore !== 32'h1234) begin errors++; $display("FAIL store_data_w%0d got %h want 1234", k, ramstore); end
      checks++; if (ramaddr !== 32'h200) begin errors++; $display("FAIL store_addr_w%0d got %h want 200", k, ramaddr); end
      checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL store_early_dhit_w%0d got %b want 0", k, dhit); end
    end
    @(negedge CLK); ram_ready = 1; #1;
    checks++; if ({ramWEN, ramREN} !== 2'b10) begin errors++; $display("FAIL store_strobes_ready got %b want 10", {ramWEN, ramREN}); end
    checks++; if (ramstore !== 32'h1234) begin errors++; $display("FAIL store_data_ready got %h want 1234", ramstore); end
    checks++; if (dhit !== 1'b1) begin errors++; $display("FAIL store_dhit got %b want 1", dhit); end
    dWEN = 0; dREN = 0;
    @(negedge CLK); ram_ready = 0; #1;
    checks++; if ({ramWEN, ramREN} !== 2'b00) begin errors++; $display("FAIL store_done_strobes got %b want 00", {ramWEN, ramREN}); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL store_no_err got %b want 0", err); end
  endtask

  task automatic test_timeout();
    @(negedge CLK); dREN = 1; daddr = 32'h300; ram_ready = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); #1;
      checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL to_ramREN_w%0d got %b want 1", k, ramREN); end
      checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL to_dhit_w%0d got %b want 0", k, dhit); end
    end
    dREN = 0;
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL to_strobe_drop got %b want 0", ramREN); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err); end
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL to_no_hit got %b want 0", dhit); end
    // A later successful fetch must not clear the sticky flag.
    iREN = 1; iaddr = 32'h44;
    @(negedge CLK); ram_ready = 1; #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL to_after_ihit got %b want 1", ihit); end
    iREN = 0;
    @(negedge CLK); ram_ready = 0;
    @(negedge CLK); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_midop();
    @(negedge CLK); dREN = 1; dWEN = 0; daddr = 32'h400; ram_ready = 0;
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rmid_in_dreq got %b want 1", ramREN); end
    nRST = 0; ram_ready = 1; #1;
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL rmid_strobes got %b want 00", {ramREN, ramWEN}); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", err); end
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL rmid_dhit got %b want 0", dhit); end
    dREN = 0;
    @(negedge CLK); nRST = 1; #1;
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL rmid_release_dhit got %b want 0", dhit); end
    @(negedge CLK); #1;
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL rmid_idle_dhit got %b want 0", dhit); end
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rmid_idle_ramREN got %b want 0", ramREN); end
    ram_ready = 0;
  endtask

`ifdef MEM_ARBITER_STATS_EN
  task automatic do_access(input bit is_data, input logic [W-1:0] addr);
    @(negedge CLK);
    if (is_data) begin dREN = 1; daddr = addr; end
    else begin iREN = 1; iaddr = addr; end
    @(negedge CLK); ram_ready = 1; ramload = addr ^ 32'hA5A5_0000;
    dREN = 0; iREN = 0;
    @(negedge CLK); ram_ready = 0;
  endtask

  task automatic test_stats();
    #1;
    checks++; if ({icount, dcount} !== 64'h0) begin errors++; $display("FAIL stats_reset got %h want 0", {icount, dcount}); end
    do_access(1'b0, 32'h10);
    do_access(1'b1, 32'h20);
    do_access(1'b0, 32'h14);
    do_access(1'b1, 32'h24);
    do_access(1'b0, 32'h18);
    #1;
    checks++; if (icount !== 32'd3) begin errors++; $display("FAIL stats_icount got %0d want 3", icount); end
    checks++; if (dcount !== 32'd2) begin errors++; $display("FAIL stats_dcount got %0d want 2", dcount); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_timeout();
    test_reset_midop();
`ifdef MEM_ARBITER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
